viterbi_ctrl: RTL and testbench

// - Sequencer for a bank of I viterbi PEs, one per destination state j. Fetches observations and seeds δ[0].
// - Steps the PE array through a sequence of up to T_MAX observations and stores the ψ backpointers.
// - Finds the terminal best state, then traces back to stream out the decoded state path.
// - Sits between the observation/backpointer memories and the PE array. logA columns go to the PEs

---
 rtl/viterbi_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_viterbi_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_ctrl.sv
// Viterbi sequencer: seeds δ[0], steps the PE bank, scans for the best terminal state, then traces back.
// Optional macro VITERBI_CTRL_NORM_EN: subtract the per-step maximum from δ when capturing PE results.
module viterbi_ctrl #(
    parameter int I      = 3,
    parameter int W      = 20,
    parameter int T_MAX  = 64,
    localparam int SW    = (I > 1) ? $clog2(I) : 1,
    localparam int LW    = $clog2(T_MAX + 1),
    localparam int AW    = $clog2(T_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LW-1:0]     seq_len,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     obs_addr,
    input  logic [SW-1:0]     obs_data,
    output logic [SW-1:0]     cur_obs,
    input  logic [I*W-1:0]    emit_row,
    input  logic [I*W-1:0]    log_pi,
    output logic [I*W-1:0]    delta_bank,
    input  logic [I*W-1:0]    pe_delta,
    input  logic [I*SW-1:0]   pe_psi,
    output logic              bp_we,
    output logic [AW-1:0]     bp_addr,
    output logic [I*SW-1:0]   bp_wdata,
    input  logic [I*SW-1:0]   bp_rdata,
    output logic              path_valid,
    output logic [AW-1:0]     path_idx,
    output logic [SW-1:0]     path_state,
    output logic [W-1:0]      final_score
);

    typedef enum logic [3:0] {
        S_IDLE, S_I_FETCH, S_I_LOAD, S_I_SUM,
        S_FETCH, S_LOAD, S_EVAL1, S_EVAL2, S_CAP,
        S_TERM, S_TR_RD, S_TR_SEL, S_DONE
    } state_t;

    function automatic logic signed [W-1:0] add_wrap(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        return a + b;
    endfunction

    function automatic logic signed [W-1:0] sub_wrap(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        return a - b;
    endfunction

    state_t              state;
    logic [AW-1:0]       n;
    logic [AW-1:0]       t_last;
    logic [SW-1:0]       scan_k;
    logic [SW-1:0]       best_s;
    logic signed [W-1:0] best_v;

    logic [LW-1:0]       t_clamp;
    logic [I*W-1:0]      init_sum;
    logic [I*W-1:0]      cap_bank;
    logic signed [W-1:0] scan_v;
    logic                scan_gt;
    logic signed [W-1:0] term_v;
    logic [SW-1:0]       term_s;
    logic [SW-1:0]       bp_sel;

    assign t_clamp = (seq_len > LW'(T_MAX)) ? LW'(T_MAX) : seq_len;

    always_comb begin
        init_sum = '0;
        for (int j = 0; j < I; j++)
            init_sum[j*W +: W] = add_wrap($signed(log_pi[j*W +: W]), $signed(emit_row[j*W +: W]));
    end

`ifdef VITERBI_CTRL_NORM_EN
    logic signed [W-1:0] pe_max;

    always_comb begin
        pe_max = $signed(pe_delta[W-1:0]);
        for (int j = 1; j < I; j++)
            if ($signed(pe_delta[j*W +: W]) > pe_max)
                pe_max = $signed(pe_delta[j*W +: W]);
    end

    always_comb begin
        cap_bank = '0;
        for (int j = 0; j < I; j++)
            cap_bank[j*W +: W] = sub_wrap($signed(pe_delta[j*W +: W]), pe_max);
    end
`else
    assign cap_bank = pe_delta;
`endif

    // Terminal scan: strict '>' keeps the lowest index on ties; slot 0 seeds the running max.
    assign scan_v  = $signed(delta_bank[scan_k*W +: W]);
    assign scan_gt = (scan_k == '0) || (scan_v > best_v);
    assign term_v  = scan_gt ? scan_v : best_v;
    assign term_s  = scan_gt ? scan_k : best_s;
    assign bp_sel  = bp_rdata[best_s*SW +: SW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            n           <= '0;
            t_last      <= '0;
            scan_k      <= '0;
            best_s      <= '0;
            best_v      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            obs_addr    <= '0;
            cur_obs     <= '0;
            delta_bank  <= '0;
            bp_we       <= 1'b0;
            bp_addr     <= '0;
            bp_wdata    <= '0;
            path_valid  <= 1'b0;
            path_idx    <= '0;
            path_state  <= '0;
            final_score <= '0;
        end else begin
            done       <= 1'b0;
            bp_we      <= 1'b0;
            path_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (t_clamp == '0) begin
                            final_score <= '0;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            busy     <= 1'b1;
                            t_last   <= AW'(t_clamp - 1'b1);
                            obs_addr <= '0;
                            state    <= S_I_FETCH;
                        end
                    end
                end
                S_I_FETCH: state <= S_I_LOAD;
                S_I_LOAD: begin
                    cur_obs <= obs_data;
                    state   <= S_I_SUM;
                end
                S_I_SUM: begin
                    delta_bank <= init_sum;
                    if (t_last == '0) begin
                        scan_k <= '0;
                        state  <= S_TERM;
                    end else begin
                        n        <= AW'(1);
                        obs_addr <= AW'(1);
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    cur_obs <= obs_data;
                    state   <= S_EVAL1;
                end
                S_EVAL1: state <= S_EVAL2;
                S_EVAL2: state <= S_CAP;
                // PE results are valid here; the backpointer write lands the following cycle.
                S_CAP: begin
                    delta_bank <= cap_bank;
                    bp_we      <= 1'b1;
                    bp_addr    <= n;
                    bp_wdata   <= pe_psi;
                    if (n == t_last) begin
                        scan_k <= '0;
                        state  <= S_TERM;
                    end else begin
                        n        <= n + 1'b1;
                        obs_addr <= n + 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_TERM: begin
                    best_v <= term_v;
                    best_s <= term_s;
                    if (scan_k == SW'(I - 1)) begin
                        final_score <= term_v;
                        path_valid  <= 1'b1;
                        path_idx    <= t_last;
                        path_state  <= term_s;
                        if (t_last == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            n       <= t_last;
                            bp_addr <= t_last;
                            state   <= S_TR_RD;
                        end
                    end else begin
                        scan_k <= scan_k + 1'b1;
                    end
                end
                S_TR_RD: state <= S_TR_SEL;
                S_TR_SEL: begin
                    best_s     <= bp_sel;
                    path_valid <= 1'b1;
                    path_idx   <= n - 1'b1;
                    path_state <= bp_sel;
                    if (n == AW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n       <= n - 1'b1;
                        bp_addr <= n - 1'b1;
                        state   <= S_TR_RD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: memories and a PE bank around the DUT, a reference Viterbi decoder, and a scoreboard.
module tb_viterbi_ctrl;
    localparam int I = 3, W = 20, T_MAX = 64, SW = 2, LW = 7, AW = 6;

    logic              clk, rst_n, start;
    logic [LW-1:0]     seq_len;
    logic              busy, done, bp_we, path_valid;
    logic [AW-1:0]     obs_addr, bp_addr, path_idx;
    logic [SW-1:0]     obs_data, cur_obs, path_state;
    logic [I*W-1:0]    emit_row, log_pi, delta_bank, pe_delta;
    logic [I*SW-1:0]   pe_psi, bp_wdata, bp_rdata;
    logic [W-1:0]      final_score;

    viterbi_ctrl #(.I(I), .W(W), .T_MAX(T_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len), .busy(busy), .done(done),
        .obs_addr(obs_addr), .obs_data(obs_data), .cur_obs(cur_obs), .emit_row(emit_row),
        .log_pi(log_pi), .delta_bank(delta_bank), .pe_delta(pe_delta), .pe_psi(pe_psi),
        .bp_we(bp_we), .bp_addr(bp_addr), .bp_wdata(bp_wdata), .bp_rdata(bp_rdata),
        .path_valid(path_valid), .path_idx(path_idx), .path_state(path_state),
        .final_score(final_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int a; int b; } pair_t;
    typedef struct { int e0; int lat; longint fin; bit db_en; longint db0, db1, db2; } done_t;
    pair_t path_q[$];
    pair_t bp_q[$];
    done_t done_q[$];

    logic signed [W-1:0] log_pi_t [I];
    logic signed [W-1:0] logA [I][I];
    logic signed [W-1:0] logB [I][4];
    logic [SW-1:0]       obs_mem [T_MAX];
    logic [I*SW-1:0]     bp_mem [T_MAX];
    logic                pe_force, chk_zero;
    int                  total = 0, bad = 0, cyc = 0;

    function automatic logic signed [W-1:0] sv(input int x);
        return W'(x);
    endfunction

    always_comb begin
        log_pi = '0;
        emit_row = '0;
        for (int j = 0; j < I; j++) begin
            log_pi[j*W +: W]   = log_pi_t[j];
            emit_row[j*W +: W] = logB[j][cur_obs];
        end
    end

    // PE bank: max-plus over the previous δ, two register stages of latency.
    logic [I*W-1:0]  pe_d_c, pe_d_s1;
    logic [I*SW-1:0] pe_p_c, pe_p_s1;
    always_comb begin : pe_comb
        logic signed [W-1:0] b, v;
        logic [SW-1:0] a;
        b = '0; v = '0; a = '0;
        pe_d_c = '0;
        pe_p_c = '0;
        for (int j = 0; j < I; j++) begin
            b = $signed(delta_bank[0 +: W]) + logA[0][j];
            a = '0;
            for (int i = 1; i < I; i++) begin
                v = $signed(delta_bank[i*W +: W]) + logA[i][j];
                if (v > b) begin b = v; a = SW'(i); end
            end
            pe_d_c[j*W +: W]   = b + logB[j][cur_obs];
            pe_p_c[j*SW +: SW] = a;
        end
    end

    always @(posedge clk) begin
        pe_d_s1 <= pe_d_c;
        pe_p_s1 <= pe_p_c;
        if (pe_force) begin
            pe_delta <= {sv(-95), sv(-90), sv(-100)};
            pe_psi   <= '0;
        end else begin
            pe_delta <= pe_d_s1;
            pe_psi   <= pe_p_s1;
        end
        obs_data <= obs_mem[obs_addr];
        if (bp_we) bp_mem[bp_addr] <= bp_wdata;
        bp_rdata <= bp_mem[bp_addr];
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Monitor: every DUT output event is matched against the queued expectations.
    always @(negedge clk) begin : mon
        pair_t e;
        done_t dr;
        cyc++;
        if (chk_zero) begin
            chk("rst_busy", longint'(busy), 0);
            chk("rst_done", longint'(done), 0);
            chk("rst_bp_we", longint'(bp_we), 0);
            chk("rst_path_valid", longint'(path_valid), 0);
            chk("rst_delta_bank", longint'(delta_bank), 0);
            chk("rst_final_score", longint'(final_score), 0);
            chk("rst_addrs", longint'({obs_addr, bp_addr, cur_obs}), 0);
        end else if (rst_n) begin
            if (path_valid) begin
                if (path_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL path_extra: idx=%0d state=%0d, none required", path_idx, path_state);
                end else begin
                    e = path_q.pop_front();
                    chk("path_idx", longint'(path_idx), longint'(e.a));
                    chk("path_state", longint'(path_state), longint'(e.b));
                end
            end
            if (bp_we) begin
                if (bp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bp_extra: addr=%0d data=%0d, none required", bp_addr, bp_wdata);
                end else begin
                    e = bp_q.pop_front();
                    chk("bp_addr", longint'(bp_addr), longint'(e.a));
                    chk("bp_wdata", longint'(bp_wdata), longint'(e.b));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_extra: done=1, none required");
                end else begin
                    dr = done_q.pop_front();
                    chk("done_latency", longint'(cyc - dr.e0 - 1), longint'(dr.lat));
                    chk("final_score", $signed(final_score), dr.fin);
                    chk("busy_at_done", longint'(busy), 0);
                    chk("path_drained", longint'(path_q.size()), 0);
                    chk("bp_drained", longint'(bp_q.size()), 0);
                    if (dr.db_en) begin
                        chk("delta_bank0", $signed(delta_bank[0 +: W]), dr.db0);
                        chk("delta_bank1", $signed(delta_bank[W +: W]), dr.db1);
                        chk("delta_bank2", $signed(delta_bank[2*W +: W]), dr.db2);
                    end
                end
            end
        end
    end

    // Reference decoder: forward max-plus recursion in W-bit wrap arithmetic, then backtrack.
    task automatic model_push(input int T, output longint fin);
        logic signed [W-1:0] md [T_MAX][I];
        logic signed [W-1:0] dn [I];
        logic signed [W-1:0] v, best, mx;
        int mpsi [T_MAX][I];
        int mpath [T_MAX];
        logic [I*SW-1:0] pk;
        int arg;
        fin = 0;
        if (T == 0) return;
        for (int j = 0; j < I; j++) md[0][j] = log_pi_t[j] + logB[j][obs_mem[0]];
        for (int t = 1; t < T; t++) begin
            for (int j = 0; j < I; j++) begin
                best = md[t-1][0] + logA[0][j];
                arg = 0;
                for (int i = 1; i < I; i++) begin
                    v = md[t-1][i] + logA[i][j];
                    if (v > best) begin best = v; arg = i; end
                end
                dn[j] = best + logB[j][obs_mem[t]];
                mpsi[t][j] = arg;
                pk[j*SW +: SW] = SW'(arg);
            end
            mx = dn[0];
            for (int j = 1; j < I; j++) if (dn[j] > mx) mx = dn[j];
            for (int j = 0; j < I; j++) begin
`ifdef VITERBI_CTRL_NORM_EN
                md[t][j] = dn[j] - mx;
`else
                md[t][j] = dn[j];
`endif
            end
            bp_q.push_back('{t, int'(pk)});
        end
        best = md[T-1][0];
        arg = 0;
        for (int j = 1; j < I; j++) if (md[T-1][j] > best) begin best = md[T-1][j]; arg = j; end
        fin = longint'(best);
        mpath[T-1] = arg;
        for (int t = T - 1; t >= 1; t--) mpath[t-1] = mpsi[t][mpath[t]];
        for (int t = T - 1; t >= 0; t--) path_q.push_back('{t, mpath[t]});
    endtask

    task automatic launch(input int seq);
        @(negedge clk);
        start = 1'b1;
        seq_len = LW'(seq);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_model(input int seq);
        int T;
        longint fin;
        done_t dr;
        T = (seq > T_MAX) ? T_MAX : seq;
        model_push(T, fin);
        dr.e0 = cyc;
        dr.lat = (T == 0) ? 0 : 3 + 5*(T-1) + I + 2*(T-1);
        dr.fin = fin;
        dr.db_en = 1'b0;
        dr.db0 = 0; dr.db1 = 0; dr.db2 = 0;
        done_q.push_back(dr);
    endtask

    task automatic wait_done(input bit pulse_mid, input string nm);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
            start = pulse_mid && (k == 10);
        end
        start = 1'b0;
        if (!done) begin
            $display("FAIL %s: done not seen within %0d cycles", nm, k);
            $fatal(1, "decode timeout");
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input int seq, input bit pulse_mid, input string nm);
        launch(seq);
        expect_model(seq);
        wait_done(pulse_mid, nm);
    endtask

    task automatic rand_tables();
        for (int i = 0; i < I; i++) begin
            log_pi_t[i] = sv(-int'($urandom_range(0, 40)));
            for (int j = 0; j < I; j++) logA[i][j] = sv(-int'($urandom_range(0, 40)));
            for (int o = 0; o < 4; o++) logB[i][o] = sv(-int'($urandom_range(0, 40)));
        end
        for (int t = 0; t < T_MAX; t++) obs_mem[t] = SW'($urandom_range(0, 3));
    endtask

    task automatic zero_tables();
        for (int i = 0; i < I; i++) begin
            log_pi_t[i] = '0;
            for (int j = 0; j < I; j++) logA[i][j] = '0;
            for (int o = 0; o < 4; o++) logB[i][o] = '0;
        end
        for (int t = 0; t < T_MAX; t++) obs_mem[t] = '0;
    endtask

    initial begin
        done_t dr;
        rst_n = 1'b0; start = 1'b0; seq_len = '0; pe_force = 1'b0; chk_zero = 1'b0;
        zero_tables();
        repeat (3) @(posedge clk);
        #1 chk_zero = 1'b1;
        @(posedge clk);
        #1 chk_zero = 1'b0;
        rst_n = 1'b1;

        // T=1 directed: sums {-5,-5,-4} -> state 2, score -4
        log_pi_t[0] = sv(-1); log_pi_t[1] = sv(-5); log_pi_t[2] = sv(-3);
        logB[0][2] = sv(-4); logB[1][2] = sv(0); logB[2][2] = sv(-1);
        obs_mem[0] = 2'd2;
        decode(1, 1'b0, "t1_directed");

        // T=4 known tables
        log_pi_t[0] = sv(-2); log_pi_t[1] = sv(-6); log_pi_t[2] = sv(-4);
        logA[0][0] = sv(-1); logA[0][1] = sv(-3); logA[0][2] = sv(-5);
        logA[1][0] = sv(-4); logA[1][1] = sv(-1); logA[1][2] = sv(-3);
        logA[2][0] = sv(-3); logA[2][1] = sv(-5); logA[2][2] = sv(-1);
        logB[0][0] = sv(-1); logB[0][1] = sv(-6); logB[0][2] = sv(-3); logB[0][3] = sv(-8);
        logB[1][0] = sv(-5); logB[1][1] = sv(-1); logB[1][2] = sv(-4); logB[1][3] = sv(-2);
        logB[2][0] = sv(-3); logB[2][1] = sv(-4); logB[2][2] = sv(-1); logB[2][3] = sv(-6);
        obs_mem[0] = 2'd0; obs_mem[1] = 2'd1; obs_mem[2] = 2'd2; obs_mem[3] = 2'd1;
        decode(4, 1'b0, "t4_known");

        // Tie and empty sequence
        zero_tables();
        decode(1, 1'b0, "tie");
        decode(0, 1'b0, "empty");

        // Reset during EVAL1 of step 2, then a clean redo
        rand_tables();
        launch(5);
        expect_model(5);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        path_q.delete(); bp_q.delete(); done_q.delete();
        chk_zero = 1'b1;
        @(posedge clk);
        #1 chk_zero = 1'b0;
        rst_n = 1'b1;
        decode(5, 1'b0, "abort_redo");

        // Forced PE outputs for one step
        pe_force = 1'b1;
        launch(2);
        bp_q.push_back('{1, 0});
        path_q.push_back('{1, 1});
        path_q.push_back('{0, 0});
        dr.e0 = cyc; dr.lat = 13; dr.db_en = 1'b1;
`ifdef VITERBI_CTRL_NORM_EN
        dr.fin = 0; dr.db0 = -10; dr.db1 = 0; dr.db2 = -5;
`else
        dr.fin = -90; dr.db0 = -100; dr.db1 = -90; dr.db2 = -95;
`endif
        done_q.push_back(dr);
        wait_done(1'b0, "forced_pe");
        pe_force = 1'b0;

        // Random decodes; one with a start pulse while busy
        for (int r = 0; r < 8; r++) begin
            rand_tables();
            decode(int'($urandom_range(1, 12)) + ((r == 3) ? 2 : 0), r == 3, "random");
        end

        // Over-length request clamps to T_MAX
        rand_tables();
        decode(100, 1'b0, "clamp");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
